vec_mem_stage: RTL and testbench

Memory-access pipeline stage for the vector datapath. It accepts one load/store request at a time from execute over a valid/ready handshake and drives the 16-lane banked memory controller's `address`/`data`/`wren`/`vec_scalar` inputs. It waits out the fixed RAM read latency, captures `q`, and presents the result to writeback over a second valid/ready handshake. Every accepted request produces exactly one response, including stores and out-of-range accesses.

---
 rtl/vec_mem_stage.sv | 117 +++++++++++
 tb/tb_vec_mem_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_stage.sv
// Memory-access pipeline stage: accepts one load/store at a time, drives the
// banked memory controller, waits out the read latency and returns one response.
module vec_mem_stage #(
  parameter int LANES    = 16,
  parameter int DW       = 16,
  parameter int AW       = 18,
  parameter int RD_W     = 5,
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic                  req_vec,
  input  logic [AW-1:0]         req_addr,
  input  logic [LANES*DW-1:0]   req_data,
  input  logic [RD_W-1:0]       req_rd,
  output logic [AW-1:0]         mem_address,
  output logic [LANES*DW-1:0]   mem_data,
  output logic                  mem_wren,
  output logic                  mem_vec_scalar,
  input  logic [LANES*DW-1:0]   mem_q,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LANES*DW-1:0]   resp_data,
  output logic [RD_W-1:0]       resp_rd,
  output logic                  resp_load,
  output logic                  resp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = $clog2(READ_LAT + 1);
  // ISSUE already covers one latency cycle, so WAIT runs READ_LAT-1 cycles
  // and captures when the counter reaches zero.
  localparam logic [CW-1:0] CNT_INIT = CW'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);
  localparam logic [AW-1:0] MAX_VEC_BASE = {AW{1'b1}} - AW'(LANES - 1);
  localparam logic [LANES*DW-1:0] LANE0_MASK = {{((LANES - 1) * DW){1'b0}}, {DW{1'b1}}};

  state_t                state, state_nxt;
  logic                  lat_store;
  logic                  lat_vec;
  logic [AW-1:0]         lat_addr;
  logic [LANES*DW-1:0]   lat_data;
  logic [CW-1:0]         cnt;
  logic                  range_err;
  logic                  capture;
  logic [LANES*DW-1:0]   q_masked;

  assign range_err = req_vec && (req_addr > MAX_VEC_BASE);
  assign q_masked  = lat_vec ? mem_q : (mem_q & LANE0_MASK);

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign mem_address    = lat_addr;
  assign mem_vec_scalar = lat_vec;
  assign mem_data       = lat_vec ? lat_data : (lat_data & LANE0_MASK);
  assign mem_wren       = (state == ISSUE) && lat_store;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:  if (req_valid) state_nxt = range_err ? RESP : ISSUE;
      ISSUE: begin
        if (lat_store) begin
          state_nxt = RESP;
        end else if (READ_LAT == 1) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_store <= 1'b0;
      lat_vec   <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
      resp_load <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        lat_store <= req_store;
        lat_vec   <= req_vec;
        lat_addr  <= req_addr;
        lat_data  <= req_data;
        resp_rd   <= req_rd;
        resp_load <= !req_store;
        resp_err  <= range_err;
        resp_data <= '0;
      end
      if (state == ISSUE) cnt <= CNT_INIT;
      if (state == WAIT)  cnt <= cnt - 1'b1;
      if (capture) resp_data <= q_masked;
    end
  end

endmodule

// File: tb/tb_vec_mem_stage.sv
// Directed self-checking bench for vec_mem_stage with a behavioural banked
// memory (READ_LAT=2 instance) and a pattern ROM (READ_LAT=1 instance).
module tb_vec_mem_stage;
  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam int AW    = 18;
  localparam int RD_W  = 5;
  localparam int VW    = LANES * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid = 1'b0, req_valid1 = 1'b0;
  logic            req_store = 1'b0, req_vec = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [VW-1:0]   req_data = '0;
  logic [RD_W-1:0] req_rd = '0;

  logic            req_ready, mem_wren, mem_vec_scalar, resp_valid, resp_load, resp_err;
  logic [AW-1:0]   mem_address;
  logic [VW-1:0]   mem_data, mem_q, resp_data;
  logic [RD_W-1:0] resp_rd;

  logic            req_ready1, mem_wren1, mem_vec_scalar1, resp_valid1, resp_load1, resp_err1;
  logic [AW-1:0]   mem_address1;
  logic [VW-1:0]   mem_data1, mem_q1, resp_data1;
  logic [RD_W-1:0] resp_rd1;

  vec_mem_stage #(.LANES(LANES), .DW(DW), .AW(AW), .RD_W(RD_W), .READ_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_vec(req_vec), .req_addr(req_addr), .req_data(req_data),
    .req_rd(req_rd), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_vec_scalar(mem_vec_scalar), .mem_q(mem_q), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_load(resp_load), .resp_err(resp_err)
  );

  vec_mem_stage #(.LANES(LANES), .DW(DW), .AW(AW), .RD_W(RD_W), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_store(req_store), .req_vec(req_vec), .req_addr(req_addr), .req_data(req_data),
    .req_rd(req_rd), .mem_address(mem_address1), .mem_data(mem_data1), .mem_wren(mem_wren1),
    .mem_vec_scalar(mem_vec_scalar1), .mem_q(mem_q1), .resp_valid(resp_valid1),
    .resp_ready(resp_ready), .resp_data(resp_data1), .resp_rd(resp_rd1),
    .resp_load(resp_load1), .resp_err(resp_err1)
  );

  // Controller model: lane i at base+i, one registered read stage (READ_LAT=2).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

  always @(posedge clk) begin : ctrl_model
    logic [AW-1:0] a;
    if (mem_wren) begin
      if (mem_vec_scalar) begin
        for (int i = 0; i < LANES; i++) begin
          a = mem_address + AW'(i);
          mem[a] = mem_data[i*DW +: DW];
        end
      end else begin
        mem[mem_address] = mem_data[DW-1:0];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      a = mem_address + AW'(i);
      mem_q[i*DW +: DW] <= mem[a];
    end
  end

  // Combinational pattern source for the READ_LAT=1 instance.
  always_comb begin
    mem_q1 = '0;
    for (int i = 0; i < LANES; i++)
      mem_q1[i*DW +: DW] = 16'(mem_address1 + AW'(i)) ^ 16'h5A5A;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the READ_LAT=2 instance; lat counts cycles from
  // acceptance to resp_valid (1 = the cycle right after the accepting edge).
  task automatic do_req(input logic st, input logic vc, input logic [AW-1:0] ad,
                        input logic [VW-1:0] d, input logic [RD_W-1:0] rd,
                        output int lat, output int wr, output logic vs_issue,
                        output logic [VW-1:0] md_issue);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_store = st; req_vec = vc; req_addr = ad; req_data = d; req_rd = rd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '1; req_data = '1; req_rd = '1;
    req_store = ~st; req_vec = ~vc;
    lat = 1;
    wr = mem_wren ? 1 : 0;
    vs_issue = mem_vec_scalar;
    md_issue = mem_data;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mem_wren) wr++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, wr;
    logic vs;
    logic [VW-1:0] md, ev, snap_d;
    logic [RD_W-1:0] snap_rd;

    #12;
    chk("rst_mem_data", mem_data, '0);
    chk("rst_ctrl", {mem_wren, mem_vec_scalar, mem_address, resp_valid, resp_rd, resp_load, resp_err}, '0);
    chk("rst_resp_data", resp_data, '0);
    @(negedge clk); rst = 1'b1; #1;
    chk("req_ready_after_rst", req_ready, 1'b1);

    // Vector store then vector load at 0x00100
    for (int i = 0; i < LANES; i++) ev[i*DW +: DW] = 16'h1000 + 16'(i);
    do_req(1'b1, 1'b1, 18'h00100, ev, 5'd1, lat, wr, vs, md);
    chk("vst_latency", lat, 2);
    chk("vst_wren_cycles", wr, 1);
    chk("vst_vec_scalar", vs, 1'b1);
    chk("vst_resp", {resp_load, resp_err, resp_rd}, {1'b0, 1'b0, 5'd1});
    chk("vst_resp_data", resp_data, '0);
    consume();
    do_req(1'b0, 1'b1, 18'h00100, '0, 5'd2, lat, wr, vs, md);
    chk("vld_latency", lat, 3);
    chk("vld_wren_cycles", wr, 0);
    chk("vld_data", resp_data, ev);
    chk("vld_resp", {resp_load, resp_err, resp_rd}, {1'b1, 1'b0, 5'd2});
    chk("vld_addr_held", mem_address, 18'h00100);
    consume();

    // Scalar store into a preloaded block
    ev = {LANES{16'hAAAA}};
    do_req(1'b1, 1'b1, 18'h00200, ev, 5'd3, lat, wr, vs, md);
    consume();
    do_req(1'b1, 1'b0, 18'h00200, {{(LANES-1){16'hFFFF}}, 16'h1234}, 5'd4, lat, wr, vs, md);
    chk("sst_vec_scalar", vs, 1'b0);
    chk("sst_mem_data_masked", md, {{(LANES-1){16'h0000}}, 16'h1234});
    chk("sst_latency", lat, 2);
    chk("sst_wren_cycles", wr, 1);
    consume();
    do_req(1'b0, 1'b1, 18'h00200, '0, 5'd5, lat, wr, vs, md);
    chk("sst_readback", resp_data, {{(LANES-1){16'hAAAA}}, 16'h1234});
    consume();
    do_req(1'b0, 1'b0, 18'h00201, '0, 5'd6, lat, wr, vs, md);
    chk("sld_latency", lat, 3);
    chk("sld_data", resp_data, {{(LANES-1){16'h0000}}, 16'hAAAA});
    consume();

    // Range check boundary
    do_req(1'b0, 1'b1, 18'h3FFF1, '0, 5'd8, lat, wr, vs, md);
    chk("err_latency", lat, 1);
    chk("err_flags", {resp_err, resp_load, resp_rd}, {1'b1, 1'b1, 5'd8});
    chk("err_data", resp_data, '0);
    chk("err_wren_cycles", wr, 0);
    consume();
    do_req(1'b0, 1'b1, 18'h3FFF0, '0, 5'd9, lat, wr, vs, md);
    chk("edge_ok_err", resp_err, 1'b0);
    chk("edge_ok_latency", lat, 3);
    consume();
    do_req(1'b0, 1'b0, 18'h3FFFF, '0, 5'd10, lat, wr, vs, md);
    chk("scalar_top_err", resp_err, 1'b0);
    consume();
    do_req(1'b1, 1'b1, 18'h3FFF8, {LANES{16'hBEEF}}, 5'd11, lat, wr, vs, md);
    chk("err_store_wren_cycles", wr, 0);
    chk("err_store_latency", lat, 1);
    chk("err_store_model_untouched", mem[18'h3FFF8], 16'h0000);
    consume();

    // Writeback backpressure with a competing request waiting
    for (int i = 0; i < LANES; i++) ev[i*DW +: DW] = 16'h1000 + 16'(i);
    do_req(1'b0, 1'b1, 18'h00100, '0, 5'd7, lat, wr, vs, md);
    chk("bp_first_data", resp_data, ev);
    snap_d = resp_data; snap_rd = resp_rd;
    @(negedge clk);
    req_store = 1'b1; req_vec = 1'b1; req_addr = 18'h00300; req_data = {LANES{16'h5555}};
    req_rd = 5'd9; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold", {resp_valid, req_ready, mem_wren, resp_rd}, {1'b1, 1'b0, 1'b0, 5'd7});
      chk("bp_data", resp_data, snap_d);
    end
    chk("bp_rd_snapshot", snap_rd, 5'd7);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("bp_released_ready", {req_ready, resp_valid}, 2'b10);
    @(posedge clk); #1; req_valid = 1'b0;
    chk("bp_next_issue", {req_ready, mem_wren, mem_address}, {1'b0, 1'b1, 18'h00300});
    @(posedge clk); #1;
    chk("bp_next_resp", {resp_valid, resp_rd}, {1'b1, 5'd9});
    consume();

    // Reset while waiting on a load
    @(negedge clk);
    req_store = 1'b0; req_vec = 1'b1; req_addr = 18'h00100; req_rd = 5'd3; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("rw_issue_addr", mem_address, 18'h00100);
    @(posedge clk); #1;
    chk("rw_in_wait", {resp_valid, req_ready}, 2'b00);
    #2; rst = 1'b0; #1;
    chk("rw_async_ctrl", {mem_wren, mem_vec_scalar, mem_address, resp_valid, resp_rd, resp_load, resp_err}, '0);
    chk("rw_async_data", resp_data, '0);
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("rw_no_stale", {resp_valid, req_ready}, 2'b01);
    end

    // Reset during a store's issue cycle drops the write
    @(negedge clk);
    req_store = 1'b1; req_vec = 1'b1; req_addr = 18'h00400; req_data = {LANES{16'h7777}};
    req_rd = 5'd4; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("ri_wren_before", mem_wren, 1'b1);
    rst = 1'b0; #1;
    chk("ri_wren_async", mem_wren, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ri_no_write", mem[18'h00400], 16'h0000);
    chk("ri_idle", {resp_valid, req_ready}, 2'b01);

    // READ_LAT=1 instance
    for (int i = 0; i < LANES; i++) ev[i*DW +: DW] = (16'h0300 + 16'(i)) ^ 16'h5A5A;
    @(negedge clk);
    chk("l1_ready", req_ready1, 1'b1);
    req_store = 1'b0; req_vec = 1'b1; req_addr = 18'h00300; req_data = {LANES{16'h0F0F}};
    req_rd = 5'd11; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_addr = '1;
    chk("l1_issue_ctrl", {mem_wren1, mem_vec_scalar1, mem_address1}, {1'b0, 1'b1, 18'h00300});
    chk("l1_issue_data", mem_data1, {LANES{16'h0F0F}});
    lat = 1;
    while (!resp_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("l1_latency", lat, 2);
    chk("l1_data", resp_data1, ev);
    chk("l1_resp", {resp_rd1, resp_load1, resp_err1}, {5'd11, 1'b1, 1'b0});
    consume();
    chk("l1_idle", {resp_valid1, req_ready1}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
